mac_accumulator: RTL



---
 rtl/mac_accumulator.sv | 94 +++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums LEN consecutive 8-bit products into an ACC_W-bit
// accumulator and presents each completed sum, with a sticky carry-out flag,
// on a valid/ready output handshake.
module mac_accumulator #(
  parameter int ACC_W = 12,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int         SUM_W = ACC_W + 1;
  localparam logic [7:0] LAST  = 8'(LEN - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [7:0]       cnt, cnt_nx;
  logic             ovf_r, ovf_nx;
  logic             accept;
  logic [ACC_W:0]   sum;

  // One extra bit captures the carry-out of each addition.
  assign sum = {1'b0, acc} + SUM_W'(prod);

  // State register, accumulator, product counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf_r <= ovf_nx;
    end
  end

  // Handshake decode and next-state logic; clear overrides everything.
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    ovf_nx    = ovf_r;
    in_ready  = (state == ACCUM) && !clear;
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;

    if (clear) begin
      state_nx = ACCUM;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_nx = sum[ACC_W-1:0];
            ovf_nx = ovf_r | sum[ACC_W];
            if (cnt == LAST) begin
              state_nx = DONE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 8'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx = ACCUM;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
          end
        end
        default: state_nx = ACCUM;
      endcase
    end
  end

  assign result = acc;
  assign ovf    = ovf_r;

endmodule
